// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow on the accepting edge.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd_addr,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [1:0]      op_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] quo, rem, dvs;
   logic [CW-1:0]   cnt;
   logic            qsign, rsign, dzero;

   logic            accept, signed_op, dz_in, fast;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN:0]   rem_sh, diff;
   logic [XLEN-1:0] q_res, r_res;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready && !flush;

   assign signed_op = ~op[0];
   assign mag1      = (signed_op && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
   assign mag2      = (signed_op && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
   assign dz_in     = (rs2_data == '0);

`ifdef DIV_FAST_PATH_EN
   logic ovf;
   assign ovf  = signed_op && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
   assign fast = dz_in || ovf;
`else
   assign fast = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
         CALC:    if (cnt == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Trial subtract: the borrow out of bit XLEN says the shifted remainder was below the divisor.
   assign rem_sh = {rem, quo[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         rd_q  <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         qsign <= 1'b0;
         rsign <= 1'b0;
         dzero <= 1'b0;
      end else if (accept) begin
         op_q  <= op;
         rd_q  <= rd_addr;
         dvs   <= mag2;
         quo   <= mag1;
         // Fast divide-by-zero needs the remainder already in place; overflow wants zero.
         rem   <= (fast && dz_in) ? mag1 : '0;
         cnt   <= CW'(XLEN-1);
         qsign <= signed_op && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
         rsign <= signed_op && rs1_data[XLEN-1];
         dzero <= dz_in;
      end else if (state == CALC && !flush) begin
         if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
         end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
         end
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   // Divide-by-zero quotient is forced; every other corner falls out of the sign correction.
   assign q_res = dzero ? '1 : (qsign ? -quo : quo);
   assign r_res = rsign ? -rem : rem;

   assign out_data    = (state == DONE) ? (op_q[1] ? r_res : q_res) : '0;
   assign out_rd_addr = rd_q;

endmodule
